// File: rtl/buffer_wr_arbiter.sv
// Write-port arbiter: NREQ producers share one circular-buffer write port.
// Round-robin grant with a per-grant burst limit. The owner's request and
// data are muxed straight through to the buffer port.
module buffer_wr_arbiter #(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned PAR_WRITE = 1,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned BURST     = 2,
  localparam int unsigned DW       = PAR_WRITE * SIZE,
  localparam int unsigned GW       = $clog2(NREQ),
  localparam int unsigned CW       = $clog2(BURST + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] din_all,
  input  logic               buf_ready,
  output logic [NREQ-1:0]    ack,
  output logic               wen,
  output logic [DW-1:0]      din,
  output logic [GW-1:0]      grant_id,
  output logic               busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  state_e        state_q;
  logic [GW-1:0] ptr_q;
  logic [GW-1:0] grant_q;
  logic [CW-1:0] beat_cnt_q;

  logic [GW-1:0] ptr_d;
  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] scan_idx;
  int unsigned   scan_v;
  logic          owner_req;
  logic          accept;

  // Round-robin search: first set request at or above ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_v    = 0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_v   = (32'(ptr_q) + k) % NREQ;
      scan_idx = GW'(scan_v);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Priority moves to the producer just after the one releasing the port.
  always_comb begin
    ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
  end

  // Owner-side handshake; reset gates everything off immediately.
  always_comb begin
    busy      = (state_q == ST_WRITE) && !rst;
    owner_req = req[grant_q];
    wen       = busy && owner_req;
    accept    = wen && buf_ready;
    ack       = '0;
    if (accept) begin
      ack[grant_q] = 1'b1;
    end
  end

  // Data mux selecting the owner's slice.
  always_comb begin
    din = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q == GW'(i)) begin
        din = din_all[i*DW +: DW];
      end
    end
  end

  assign grant_id = grant_q;

  // Arbitration FSM: IDLE picks a winner, WRITE streams up to BURST beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            grant_q    <= win_idx;
            beat_cnt_q <= '0;
            state_q    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!owner_req) begin
            state_q <= ST_IDLE;
            ptr_q   <= ptr_d;
          end else if (buf_ready) begin
            beat_cnt_q <= beat_cnt_q + CW'(1);
            if (beat_cnt_q == CW'(BURST - 1)) begin
              state_q <= ST_IDLE;
              ptr_q   <= ptr_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_wr_arbiter.sv
// Scenario bench for buffer_wr_arbiter (NREQ=4, BURST=2, SIZE=8, PAR_WRITE=1).
module tb_buffer_wr_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned BURST = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din_all;
  logic        buf_ready;
  logic [3:0]  ack;
  logic        wen;
  logic [7:0]  din;
  logic [1:0]  grant_id;
  logic        busy;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [3:0] mon_ack;
  int         total = 0;
  int         bad   = 0;
  bit         mon_en = 1'b0;

  buffer_wr_arbiter #(
    .SIZE(8), .PAR_WRITE(1), .NREQ(NREQ), .BURST(BURST)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .din_all(din_all),
    .buf_ready(buf_ready), .ack(ack), .wen(wen), .din(din),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wen === 1'b0 && ack !== 4'b0000) begin
        total++; bad++;
        $display("FAIL ack_without_wen got ack=%b wen=%b expected ack=0000", ack, wen);
      end
      if (ack !== 4'b0000) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack got ack=%b id=%0d din=%h expected no beat", ack, grant_id, din);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_ack = 4'b0001 << mon_e.id;
          if (ack !== mon_ack || din !== mon_e.data || grant_id !== mon_e.id) begin
            bad++;
            $display("FAIL beat got ack=%b id=%0d din=%h expected ack=%b id=%0d din=%h",
                     ack, grant_id, din, mon_ack, mon_e.id, mon_e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    din_all[i*8 +: 8] = v;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int maxc, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got %0d beats pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; buf_ready = 1'b0; din_all = '0;
    step(); step();
    mon_en = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || wen !== 1'b0 || ack !== 4'b0000 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b wen=%b ack=%b gid=%0d expected 0 0 0000 0", busy, wen, ack, grant_id);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || dut.ptr_q !== 2'd0) begin
      bad++;
      $display("FAIL reset_release got busy=%b ptr=%0d expected 0 0", busy, dut.ptr_q);
    end
  endtask

  task automatic test_single();
    step();
    req = 4'b0010; set_data(1, 8'hA5); buf_ready = 1'b1;
    push(2'd1, 8'hA5); push(2'd1, 8'h5A);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || wen !== 1'b0) begin
      bad++;
      $display("FAIL single_arb_cycle got busy=%b wen=%b expected 0 0", busy, wen);
    end
    step();
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || wen !== 1'b1 || din !== 8'hA5 || grant_id !== 2'd1) begin
      bad++;
      $display("FAIL single_first_beat got busy=%b wen=%b din=%h gid=%0d expected 1 1 a5 1", busy, wen, din, grant_id);
    end
    step();
    set_data(1, 8'h5A);
    step();
    req = 4'b0000;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || dut.ptr_q !== 2'd2 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_done got busy=%b ptr=%0d pending=%0d expected 0 2 0", busy, dut.ptr_q, exp_q.size());
    end
  endtask

  task automatic test_all_request();
    step();
    rst = 1'b1; req = 4'b1111; buf_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_data(i, 8'h10 + 8'(i));
    for (int g = 0; g < 5; g++) begin
      push(2'(g % 4), 8'h10 + 8'(g % 4));
      push(2'(g % 4), 8'h10 + 8'(g % 4));
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ack !== 4'b0000) begin
      bad++;
      $display("FAIL all_in_reset got busy=%b ack=%b expected 0 0000", busy, ack);
    end
    step();
    rst = 1'b0;
    wait_drain(40, "all_request");
    req = 4'b0000;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || dut.ptr_q !== 2'd1) begin
      bad++;
      $display("FAIL all_done got busy=%b ptr=%0d expected 0 1", busy, dut.ptr_q);
    end
  endtask

  task automatic test_backpressure();
    step();
    req = 4'b1000; set_data(3, 8'hC3); buf_ready = 1'b1;
    push(2'd3, 8'hC3); push(2'd3, 8'h3C);
    step();
    step();
    set_data(3, 8'h3C); buf_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (wen !== 1'b1 || din !== 8'h3C || ack !== 4'b0000 || grant_id !== 2'd3 || busy !== 1'b1) begin
        bad++;
        $display("FAIL stall_%0d got wen=%b din=%h ack=%b gid=%0d busy=%b expected 1 3c 0000 3 1",
                 c, wen, din, ack, grant_id, busy);
      end
      step();
    end
    buf_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ack !== 4'b1000) begin
      bad++;
      $display("FAIL stall_release got ack=%b expected 1000", ack);
    end
    step();
    req = 4'b0000;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || dut.ptr_q !== 2'd0) begin
      bad++;
      $display("FAIL ptr_wrap got busy=%b ptr=%0d expected 0 0", busy, dut.ptr_q);
    end
  endtask

  task automatic test_early_release();
    step();
    req = 4'b0010; set_data(1, 8'h11); buf_ready = 1'b1;
    push(2'd1, 8'h11);
    step();
    step();
    req = 4'b0101; set_data(0, 8'h20); set_data(2, 8'h22);
    push(2'd2, 8'h22); push(2'd2, 8'h22);
    @(negedge clk);
    total++;
    if (wen !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL early_drop got wen=%b ack=%b busy=%b expected 0 0000 1", wen, ack, busy);
    end
    step();
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || dut.ptr_q !== 2'd2) begin
      bad++;
      $display("FAIL early_idle got busy=%b ptr=%0d expected 0 2", busy, dut.ptr_q);
    end
    step();
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL early_next_grant got busy=%b gid=%0d expected 1 2", busy, grant_id);
    end
    wait_drain(10, "early_release");
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    step();
    req = 4'b0100; set_data(2, 8'h44); buf_ready = 1'b1;
    push(2'd2, 8'h44);
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (wen !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_outputs got wen=%b ack=%b busy=%b expected 0 0000 0", wen, ack, busy);
    end
    step();
    rst = 1'b0; req = 4'b0101; set_data(0, 8'h20); set_data(2, 8'h22);
    push(2'd0, 8'h20); push(2'd0, 8'h20);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || dut.ptr_q !== 2'd0 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL rst_mid_state got busy=%b ptr=%0d gid=%0d expected 0 0 0", busy, dut.ptr_q, grant_id);
    end
    step();
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL rst_mid_grant got busy=%b gid=%0d expected 1 0", busy, grant_id);
    end
    wait_drain(10, "reset_mid");
    req = 4'b0000;
  endtask

  task automatic test_idle_hold();
    step();
    req = 4'b0000; buf_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (wen !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000 || dut.ptr_q !== 2'd1) begin
        bad++;
        $display("FAIL idle_%0d got wen=%b busy=%b ack=%b ptr=%0d expected 0 0 0000 1",
                 c, wen, busy, ack, dut.ptr_q);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_request();
    test_backpressure();
    test_early_release();
    test_reset_mid();
    test_idle_hold();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_beats got %0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
